// File: rtl/lloyd_quantizer.sv
// Scalar Lloyd-Max quantiser: a sample is mapped to a bin with a fixed-length
// binary search over a programmable boundary table. The result is the bin index
// and the reconstruction level for that bin. Both tables hold signed Q8.8 values.
module lloyd_quantizer #(
  parameter int NUM_BITS_DATA = 8,
  parameter int NUM_BINS      = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cb_wr_en,
  input  logic                     cb_sel,
  input  logic [4:0]               cb_addr,
  input  logic [15:0]              cb_wdata,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_BITS_DATA-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [4:0]               out_index,
  output logic [15:0]              out_level,
  output logic [31:0]              sample_count
);

  // The search always runs this many steps, so latency is the same for every sample.
  localparam int         STEPS     = $clog2(NUM_BINS);
  localparam logic [2:0] LAST_STEP = 3'(STEPS - 1);
  localparam logic [4:0] TOP_BIN   = 5'(NUM_BINS - 1);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t state_q, state_d;

  // boundary[0] is minus infinity. Its slot is never written and is never
  // used to make a decision.
  logic signed [15:0] bnd_q [NUM_BINS];
  logic signed [15:0] lvl_q [NUM_BINS];

  logic signed [15:0] x_q;
  logic signed [15:0] x_ext;
  logic signed [15:0] x_in;
  logic [4:0]         lo_q, hi_q;
  logic [4:0]         lo_nxt, hi_nxt;
  logic [4:0]         mid;
  logic [2:0]         step_q;

  logic accept;
  logic last_step;
  logic handshake;
  logic cb_bnd_wr;
  logic cb_lvl_wr;

  // A codebook write takes the cycle, so no sample is accepted while one is present.
  assign in_ready  = rst_n && (state_q == IDLE) && !cb_wr_en;
  assign accept    = in_valid && in_ready;
  assign last_step = (state_q == SEARCH) && (step_q == LAST_STEP);
  assign handshake = (state_q == DONE) && out_ready;

  assign cb_bnd_wr = cb_wr_en && (state_q == IDLE) && !cb_sel &&
                     (cb_addr != 5'd0) && (cb_addr <= TOP_BIN);
  assign cb_lvl_wr = cb_wr_en && (state_q == IDLE) && cb_sel && (cb_addr <= TOP_BIN);

  // Integer sample to Q8.8: sign-extend the sample, then shift by the 8 fraction bits.
  assign x_ext = 16'($signed(in_data));
  assign x_in  = x_ext << 8;

  // Upper midpoint, so the bin found is the highest one whose boundary is <= x.
  assign mid = 5'((6'(lo_q) + 6'(hi_q) + 6'd1) >> 1);

  // One binary-search step. When the range has collapsed, the step leaves it unchanged.
  always_comb begin
    // NOTE: give every combinational output a default first so that no path can infer a latch.
    lo_nxt = lo_q;
    hi_nxt = hi_q;
    if (lo_q != hi_q) begin
      if (x_q >= bnd_q[mid]) begin
        lo_nxt = mid;
      end else begin
        hi_nxt = mid - 5'd1;
      end
    end
  end

  // Next-state logic for the controller.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)    state_d = SEARCH;
      SEARCH:  if (last_step) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register updates from pre-edge values.
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Search registers, result registers and the consumed-sample counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q          <= '0;
      lo_q         <= '0;
      hi_q         <= '0;
      step_q       <= '0;
      out_valid    <= 1'b0;
      out_index    <= '0;
      out_level    <= '0;
      sample_count <= '0;
    end else begin
      if (accept) begin
        x_q    <= x_in;
        lo_q   <= '0;
        hi_q   <= TOP_BIN;
        step_q <= '0;
      end else if (state_q == SEARCH) begin
        lo_q   <= lo_nxt;
        hi_q   <= hi_nxt;
        step_q <= step_q + 3'd1;
      end

      // The result registers are loaded only here. They hold their values after the handshake.
      if (last_step) begin
        out_valid <= 1'b1;
        out_index <= lo_nxt;
        out_level <= lvl_q[lo_nxt];
      end else if (handshake) begin
        out_valid    <= 1'b0;
        sample_count <= sample_count + 32'd1;
      end
    end
  end

  // Codebook storage. Reset loads a uniform quantiser across the full Q8.8 range.
  always_ff @(posedge clk) begin
    // NOTE: these tables have a defined reset value, so they are built from registers
    // rather than a RAM macro that cannot be reset.
    if (!rst_n) begin
      for (int i = 0; i < NUM_BINS; i++) begin
        bnd_q[i] <= 16'(i * 2560 - 32768);
        lvl_q[i] <= 16'(((i == 0) ? -32768 : (i * 2560 - 32768)) + 1280);
      end
    end else begin
      if (cb_bnd_wr) bnd_q[cb_addr] <= cb_wdata;
      if (cb_lvl_wr) lvl_q[cb_addr] <= cb_wdata;
    end
  end

endmodule

// File: tb/tb_lloyd_quantizer.sv
// Directed bench for lloyd_quantizer. A software copy of the codebook and a
// plain-arithmetic bin search give the expected result of each sample. A monitor
// compares every valid output cycle with that expectation. Literal values
// worked out by hand fix the model at known points.
module tb_lloyd_quantizer;

  localparam int NB = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cb_wr_en;
  logic        cb_sel;
  logic [4:0]  cb_addr;
  logic [15:0] cb_wdata;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_index;
  logic [15:0] out_level;
  logic [31:0] sample_count;

  lloyd_quantizer #(.NUM_BITS_DATA(8), .NUM_BINS(NB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cb_wr_en     (cb_wr_en),
    .cb_sel       (cb_sel),
    .cb_addr      (cb_addr),
    .cb_wdata     (cb_wdata),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_index    (out_index),
    .out_level    (out_level),
    .sample_count (sample_count)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic signed [32:0] act,
                       input logic signed [32:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_bnd [NB];
  int m_lvl [NB];
  int m_count;
  int exp_idx;
  int exp_lvl;
  bit exp_valid = 1'b0;
  int acc_cyc;

  function automatic void model_reset();
    for (int i = 0; i < NB; i++) begin
      m_bnd[i] = i * 2560 - 32768;
      m_lvl[i] = ((i == 0) ? -32768 : m_bnd[i]) + 1280;
    end
    m_count = 0;
  endfunction

  // Fixed five-step search for the highest bin whose lower boundary is <= x.
  function automatic int model_index(input int x);
    int lo = 0;
    int hi = NB - 1;
    for (int s = 0; s < 5; s++) begin
      if (lo < hi) begin
        int m = (lo + hi + 1) / 2;
        if (x >= m_bnd[m]) lo = m;
        else               hi = m - 1;
      end
    end
    return lo;
  endfunction

  // Checks every valid output cycle against the model.
  always @(posedge clk) begin
    #1;
    if (rst_n && out_valid && exp_valid) begin
      check("mon_index", out_index, exp_idx);
      check("mon_level", $signed(out_level), exp_lvl);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cb_write(input bit sel, input int addr, input int data);
    logic signed [15:0] d16;
    d16      = data[15:0];
    cb_wr_en = 1'b1;
    cb_sel   = sel;
    cb_addr  = addr[4:0];
    cb_wdata = d16;
    tick();
    cb_wr_en = 1'b0;
    if (!sel && addr >= 1 && addr < NB) m_bnd[addr] = d16;
    if (sel && addr < NB)               m_lvl[addr] = d16;
  endtask

  task automatic set_expect(input int d);
    acc_cyc   = cyc;
    exp_idx   = model_index(d * 256);
    exp_lvl   = m_lvl[exp_idx];
    exp_valid = 1'b1;
  endtask

  task automatic accept(input int d);
    int waited = 0;
    while (!in_ready && waited < 50) begin
      tick();
      waited++;
    end
    check("accept_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d[7:0];
    tick();
    in_valid = 1'b0;
    set_expect(d);
  endtask

  task automatic collect(input int hold, output int idx, output int lvl);
    int n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check("latency", cyc - acc_cyc, 5);
    idx = out_index;
    lvl = $signed(out_level);
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    m_count++;
    exp_valid = 1'b0;
    check("valid_cleared", out_valid, 0);
    check("sample_count", sample_count, m_count);
    check("held_index", out_index, exp_idx);
    check("held_level", $signed(out_level), exp_lvl);
    check("idle_ready", in_ready, 1);
  endtask

  task automatic run(input int d, input int hold, output int idx, output int lvl);
    accept(d);
    collect(hold, idx, lvl);
  endtask

  // ---------------- directed sequence ----------------
  int idx, lvl, a1;
  int sweep [8] = '{-100, -78, -50, -3, 30, 60, 100, 126};

  initial begin
    rst_n     = 1'b0;
    cb_wr_en  = 1'b0;
    cb_sel    = 1'b0;
    cb_addr   = '0;
    cb_wdata  = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    model_reset();
    repeat (3) tick();

    check("rst_out_valid", out_valid, 0);
    check("rst_out_index", out_index, 0);
    check("rst_out_level", $signed(out_level), 0);
    check("rst_count", sample_count, 0);
    check("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", in_ready, 1);

    // Uniform codebook at reset.
    run(0, 0, idx, lvl);
    check("zero_index", idx, 12);
    check("zero_level", lvl, -768);
    run(-128, 0, idx, lvl);
    check("min_index", idx, 0);
    check("min_level", lvl, -31488);
    run(127, 0, idx, lvl);
    check("max_index", idx, 19);
    check("max_level", lvl, 17152);
    run(2, 0, idx, lvl);
    check("edge_index", idx, 13);
    check("edge_level", lvl, 1792);

    // Hold the result with out_ready low, then complete the handshake.
    run(5, 10, idx, lvl);

    // Back-to-back samples give one sample every 7 cycles.
    run(10, 0, idx, lvl);
    a1 = acc_cyc;
    run(20, 0, idx, lvl);
    check("throughput", acc_cyc - a1, 7);

    foreach (sweep[i]) run(sweep[i], 0, idx, lvl);

    // Reprogramming. With only boundary[5] changed, the search never reaches bin 4.
    cb_write(1'b0, 5, 16'h0000);
    cb_write(1'b1, 4, 16'h0100);
    run(-1, 0, idx, lvl);
    check("prog1_index", idx, 12);
    check("prog1_level", lvl, -768);
    cb_write(1'b0, 10, 16'h0000);
    run(-1, 0, idx, lvl);
    check("prog2_index", idx, 4);
    check("prog2_level", lvl, 256);

    // Writes to invalid addresses are ignored.
    cb_write(1'b0, 0, 16'h7FFF);
    cb_write(1'b1, 20, 16'h7FFF);
    cb_write(1'b0, 25, 16'h7FFF);
    run(-1, 0, idx, lvl);
    run(127, 0, idx, lvl);

    // A write present together with in_valid is applied first. The sample is accepted on the next cycle.
    cb_wr_en = 1'b1;
    cb_sel   = 1'b1;
    cb_addr  = 5'd12;
    cb_wdata = 16'h1234;
    in_valid = 1'b1;
    in_data  = 8'd0;
    #1;
    check("wr_blocks_ready", in_ready, 0);
    tick();
    m_lvl[12] = 16'h1234;
    cb_wr_en  = 1'b0;
    #1;
    check("ready_after_wr", in_ready, 1);
    tick();
    in_valid = 1'b0;
    set_expect(0);
    collect(0, idx, lvl);
    check("wr_first_index", idx, 12);
    check("wr_first_level", lvl, 4660);

    // A write during the search is ignored. The level is unchanged now and afterwards.
    accept(0);
    cb_wr_en = 1'b1;
    cb_sel   = 1'b1;
    cb_addr  = 5'd12;
    cb_wdata = 16'h7777;
    tick();
    tick();
    cb_wr_en = 1'b0;
    collect(0, idx, lvl);
    check("search_wr_level", lvl, 4660);
    run(0, 0, idx, lvl);
    check("search_wr_kept", lvl, 4660);

    // Reset during the third search cycle.
    accept(0);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    exp_valid = 1'b0;
    check("midrst_valid", out_valid, 0);
    check("midrst_count", sample_count, 0);
    check("midrst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    model_reset();
    #1;
    check("midrst_rel_ready", in_ready, 1);
    run(0, 0, idx, lvl);
    check("cb_reset_level", lvl, -768);
    run(-1, 0, idx, lvl);
    check("cb_reset_index", idx, 12);
    run(-78, 0, idx, lvl);
    check("cb_reset_b5_index", idx, 5);
    check("cb_reset_b5_level", lvl, -18688);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
